ms_riscv32_dmem_responder: RTL and testbench

Data-memory responder for the msrv32 core's data bus. It sits on the far side of the core's data port: it accepts the address, write data, write request, byte mask and htrans from the core's store unit. It returns read data, hready and hresp to the core's load unit and pipeline. It contains a word-organised SRAM with byte-lane writes, a configurable wait-state generator and a two-cycle AHB-style ERROR response for out-of-range accesses.

---
 rtl/ms_riscv32_dmem_pkg.sv | 22 ++
 rtl/ms_riscv32_dmem_array.sv | 35 +++
 rtl/ms_riscv32_dmem_responder.sv | 117 +++++++++++
 tb/tb_ms_riscv32_dmem_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_riscv32_dmem_pkg.sv
// Shared encodings for the msrv32 data-memory responder: AHB transfer/response
// codes, responder FSM states and the wait-counter width.
package ms_riscv32_dmem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/ms_riscv32_dmem_array.sv
// Word-organised SRAM built from four byte-lane memories, each with a
// synchronous write port and a registered read port. Contents are never reset.
module ms_riscv32_dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rdata;

            always_ff @(posedge i_clk) begin
                if (i_we[gi]) begin
                    r_mem[i_waddr] <= i_wdata[8*gi +: 8];
                end
                if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end

            assign o_rdata[8*gi +: 8] = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/ms_riscv32_dmem_responder.sv
// Data-bus slave for the msrv32 core: range decode, wait-state / error FSM and
// the read-data register in front of a byte-writable word SRAM.
module ms_riscv32_dmem_responder
    import ms_riscv32_dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
    output logic [31:0] ms_riscv32_mp_data_out,
    output logic        ms_riscv32_mp_data_hready_out,
    output logic        ms_riscv32_mp_hresp_out
);

    localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0]       MEM_BYTES = 33'(DEPTH) << 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    dmem_state_t       r_state;
    logic [WAIT_W-1:0] r_wcnt;
    logic              r_hready;
    logic              r_hresp;
    logic              r_rd_valid;

    logic              w_active;
    logic              w_sample;
    logic [31:0]       w_offset;
    logic              w_in_range;
    logic [AW-1:0]     w_index;
    logic [3:0]        w_we;
    logic              w_re;
    logic [31:0]       w_rdata;

    assign w_active   = (ms_riscv32_mp_data_htrans_in == HTRANS_NONSEQ) ||
                        (ms_riscv32_mp_data_htrans_in == HTRANS_SEQ);
    // Held off while reset is low so a reset cycle can never touch the array.
    assign w_sample   = ms_riscv32_mp_rst_in && r_hready && w_active;
    assign w_offset   = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
    assign w_in_range = (ms_riscv32_mp_dmaddr_in >= BASE_ADDR) &&
                        ({1'b0, w_offset} < MEM_BYTES);
    assign w_index    = w_offset[AW+1:2];
    assign w_we       = (w_sample && w_in_range && ms_riscv32_mp_dmwr_req_in) ?
                        ms_riscv32_mp_dmwr_mask_in : 4'b0000;
    assign w_re       = w_sample && w_in_range && !ms_riscv32_mp_dmwr_req_in;

    ms_riscv32_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (ms_riscv32_mp_clk_in),
        .i_we    (w_we),
        .i_waddr (w_index),
        .i_wdata (ms_riscv32_mp_dmdata_in),
        .i_re    (w_re),
        .i_raddr (w_index),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= '0;
            r_hready   <= 1'b1;
            r_hresp    <= HRESP_OKAY;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    r_wcnt <= r_wcnt - 1'b1;
                    if (r_wcnt == WAIT_W'(1)) begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                default: begin
                    // IDLE and ERR2 both accept a new address phase.
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                    if (w_sample) begin
                        if (!ms_riscv32_mp_dmwr_req_in) begin
                            r_rd_valid <= w_in_range;
                        end
                        if (!w_in_range) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            r_state  <= ST_WAIT;
                            r_wcnt   <= WAIT_INIT;
                            r_hready <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // The SRAM read register holds the last in-range read; a cleared valid
    // flag (reset or out-of-range read) forces the returned word to zero.
    assign ms_riscv32_mp_data_out        = r_rd_valid ? w_rdata : 32'h0;
    assign ms_riscv32_mp_data_hready_out = r_hready;
    assign ms_riscv32_mp_hresp_out       = r_hresp;

endmodule

// File: tb/tb_ms_riscv32_dmem_responder.sv
// Randomised, model-checked bench for ms_riscv32_dmem_responder: one zero-wait
// instance at base 0 and one 3-wait-state instance at a non-zero base.
module tb_ms_riscv32_dmem_responder;
    import ms_riscv32_dmem_pkg::*;

    localparam logic [31:0] BASE0  = 32'h0000_0000;
    localparam logic [31:0] BASE1  = 32'h0000_1000;
    localparam int          DEPTH0 = 256;
    localparam int          DEPTH1 = 64;
    localparam int          WS0    = 0;
    localparam int          WS1    = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] t_addr [2];
    logic [31:0] t_wdata[2];
    logic        t_wr   [2];
    logic [3:0]  t_mask [2];
    logic [1:0]  t_ht   [2];
    logic [31:0] t_dout [2];
    logic        t_hready[2];
    logic        t_hresp [2];

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] base_of [2] = '{BASE0, BASE1};
    int          depth_of[2] = '{DEPTH0, DEPTH1};
    int          ws_of   [2] = '{WS0, WS1};
    logic [31:0] mdl     [2][256];
    logic [31:0] exp_dout[2] = '{32'h0, 32'h0};

    always #5 clk = ~clk;

    ms_riscv32_dmem_responder #(.BASE_ADDR(BASE0), .DEPTH(DEPTH0), .WAIT_STATES(WS0)) dut0 (
        .ms_riscv32_mp_clk_in          (clk),
        .ms_riscv32_mp_rst_in          (rst_n),
        .ms_riscv32_mp_dmaddr_in       (t_addr[0]),
        .ms_riscv32_mp_dmdata_in       (t_wdata[0]),
        .ms_riscv32_mp_dmwr_req_in     (t_wr[0]),
        .ms_riscv32_mp_dmwr_mask_in    (t_mask[0]),
        .ms_riscv32_mp_data_htrans_in  (t_ht[0]),
        .ms_riscv32_mp_data_out        (t_dout[0]),
        .ms_riscv32_mp_data_hready_out (t_hready[0]),
        .ms_riscv32_mp_hresp_out       (t_hresp[0])
    );

    ms_riscv32_dmem_responder #(.BASE_ADDR(BASE1), .DEPTH(DEPTH1), .WAIT_STATES(WS1)) dut1 (
        .ms_riscv32_mp_clk_in          (clk),
        .ms_riscv32_mp_rst_in          (rst_n),
        .ms_riscv32_mp_dmaddr_in       (t_addr[1]),
        .ms_riscv32_mp_dmdata_in       (t_wdata[1]),
        .ms_riscv32_mp_dmwr_req_in     (t_wr[1]),
        .ms_riscv32_mp_dmwr_mask_in    (t_mask[1]),
        .ms_riscv32_mp_data_htrans_in  (t_ht[1]),
        .ms_riscv32_mp_data_out        (t_dout[1]),
        .ms_riscv32_mp_data_hready_out (t_hready[1]),
        .ms_riscv32_mp_hresp_out       (t_hresp[1])
    );

    task automatic drive(input int s, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input logic [1:0] ht);
        t_wr[s] = wr; t_addr[s] = a; t_wdata[s] = d; t_mask[s] = m; t_ht[s] = ht;
    endtask

    function automatic logic [31:0] rand_addr_in(int s);
        return base_of[s] + 32'(4 * $urandom_range(depth_of[s] - 1));
    endfunction

    function automatic logic [31:0] rand_addr_out(int s);
        case ($urandom_range(2))
            0:       return base_of[s] + 32'(4 * depth_of[s]) + 32'($urandom_range(255));
            1:       return 32'hFFFF_FFFC;
            default: return (base_of[s] != 32'h0) ? base_of[s] - 32'd4 : 32'h8000_0000;
        endcase
    endfunction

    // Junk that must be ignored while hready is low: random in-range writes.
    task automatic drive_junk(input int s);
        drive(s, 1'b1, rand_addr_in(s), $urandom, 4'hF, HTRANS_NONSEQ);
    endtask

    // Reference model: what the bus should show for one transfer.
    task automatic model_xfer(input int s, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m, input logic [1:0] ht,
                              output int ew, output logic eresp, output logic [31:0] ed);
        longint off;
        int     idx;
        ew = 0;
        eresp = 1'b0;
        if (ht == HTRANS_NONSEQ || ht == HTRANS_SEQ) begin
            off = longint'({32'h0, a}) - longint'({32'h0, base_of[s]});
            if (off >= 0 && off < 4 * longint'(depth_of[s])) begin
                idx = int'(off / 4);
                ew  = ws_of[s];
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (m[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
                end else begin
                    exp_dout[s] = mdl[s][idx];
                end
            end else begin
                ew = 1;
                eresp = 1'b1;
                if (!wr) exp_dout[s] = 32'h0;
            end
        end
        ed = exp_dout[s];
    endtask

    // Runs one transfer starting at a negedge; returns at the negedge of the
    // final data-phase cycle (hready=1), so the next call overlaps it.
    task automatic run_xfer(input int s, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m, input logic [1:0] ht,
                            output int waits, output logic first_resp, output logic last_resp,
                            output logic [31:0] dout);
        bit done;
        bit first;
        drive(s, wr, a, d, m, ht);
        @(posedge clk);
        #1;
        if (t_hready[s] !== 1'b1) drive_junk(s);
        else drive(s, 1'b0, 32'h0, 32'h0, 4'h0, HTRANS_IDLE);
        waits = 0;
        first = 1'b1;
        first_resp = 1'b0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (first) begin
                first_resp = t_hresp[s];
                first = 1'b0;
            end
            if (t_hready[s] === 1'b1 || waits > 16) begin
                done = 1'b1;
            end else begin
                waits++;
                drive_junk(s);
            end
        end
        last_resp = t_hresp[s];
        dout = t_dout[s];
        drive(s, 1'b0, 32'h0, 32'h0, 4'h0, HTRANS_IDLE);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, HTRANS_IDLE);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, HTRANS_IDLE);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (t_dout[s] !== 32'h0) $display("FAIL reset_dout[%0d]: got %h expected 00000000", s, t_dout[s]);
            else n_pass++;
            n_checks++;
            if (t_hready[s] !== 1'b1) $display("FAIL reset_hready[%0d]: got %b expected 1", s, t_hready[s]);
            else n_pass++;
            n_checks++;
            if (t_hresp[s] !== 1'b0) $display("FAIL reset_hresp[%0d]: got %b expected 0", s, t_hresp[s]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic fill_memories();
        int w, ew; logic f, l, er; logic [31:0] dv, ed, d;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < depth_of[s]; i++) begin
                d = $urandom;
                model_xfer(s, 1'b1, base_of[s] + 32'(4 * i), d, 4'hF, HTRANS_NONSEQ, ew, er, ed);
                run_xfer(s, 1'b1, base_of[s] + 32'(4 * i), d, 4'hF, HTRANS_NONSEQ, w, f, l, dv);
            end
        end
    endtask

    task automatic test_write_read();
        int w, ew; logic f, l, er; logic [31:0] dv, ed;
        model_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (w !== 0 || l !== 1'b0) $display("FAIL wr_resp: got waits=%0d hresp=%b expected waits=0 hresp=0", w, l);
        else n_pass++;
        model_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", dv);
        else n_pass++;
        n_checks++;
        if (w !== 0 || l !== 1'b0) $display("FAIL rd_resp: got waits=%0d hresp=%b expected waits=0 hresp=0", w, l);
        else n_pass++;
    endtask

    task automatic test_partial_write();
        int w, ew; logic f, l, er; logic [31:0] dv, ed;
        model_xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, HTRANS_NONSEQ, w, f, l, dv);
        model_xfer(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, HTRANS_SEQ, ew, er, ed);
        run_xfer(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, HTRANS_SEQ, w, f, l, dv);
        n_checks++;
        if (w !== 0 || l !== 1'b0) $display("FAIL mask0_resp: got waits=%0d hresp=%b expected waits=0 hresp=0", w, l);
        else n_pass++;
        model_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== 32'hDEADBEAA) $display("FAIL partial_data: got %h expected deadbeaa", dv);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        int w, ew; logic f, l, er; logic [31:0] dv, ed;
        model_xfer(1, 1'b1, BASE1 + 32'h20, 32'h12345678, 4'hF, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(1, 1'b1, BASE1 + 32'h20, 32'h12345678, 4'hF, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (w !== 3) $display("FAIL ws_write_waits: got %0d expected 3", w);
        else n_pass++;
        model_xfer(1, 1'b0, BASE1 + 32'h20, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(1, 1'b0, BASE1 + 32'h20, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (w !== 3) $display("FAIL ws_read_waits: got %0d expected 3", w);
        else n_pass++;
        n_checks++;
        if (dv !== 32'h12345678 || f !== 1'b0 || l !== 1'b0)
            $display("FAIL ws_read_data: got %h hresp=%b/%b expected 12345678 hresp=0/0", dv, f, l);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        int w, ew; logic f, l, er; logic [31:0] dv, ed;
        model_xfer(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (w !== 1 || f !== 1'b1 || l !== 1'b1)
            $display("FAIL oor_wr_resp: got waits=%0d hresp=%b/%b expected waits=1 hresp=1/1", w, f, l);
        else n_pass++;
        model_xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== mdl[0][255] || l !== 1'b0)
            $display("FAIL oor_last_word: got %h hresp=%b expected %h hresp=0", dv, l, mdl[0][255]);
        else n_pass++;
        model_xfer(0, 1'b0, 32'h408, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b0, 32'h408, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== 32'h0 || w !== 1 || l !== 1'b1)
            $display("FAIL oor_rd: got %h waits=%0d hresp=%b expected 00000000 waits=1 hresp=1", dv, w, l);
        else n_pass++;
        model_xfer(1, 1'b1, BASE1 - 32'd4, 32'h1, 4'hF, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(1, 1'b1, BASE1 - 32'd4, 32'h1, 4'hF, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (w !== 1 || f !== 1'b1 || l !== 1'b1)
            $display("FAIL oor_below_base: got waits=%0d hresp=%b/%b expected waits=1 hresp=1/1", w, f, l);
        else n_pass++;
        model_xfer(1, 1'b0, BASE1 + 32'd252, 32'h0, 4'h0, HTRANS_SEQ, ew, er, ed);
        run_xfer(1, 1'b0, BASE1 + 32'd252, 32'h0, 4'h0, HTRANS_SEQ, w, f, l, dv);
        n_checks++;
        if (dv !== mdl[1][63] || w !== 3 || l !== 1'b0)
            $display("FAIL top_word: got %h waits=%0d hresp=%b expected %h waits=3 hresp=0", dv, w, l, mdl[1][63]);
        else n_pass++;
    endtask

    task automatic test_idle_no_write();
        int w, ew; logic f, l, er; logic [31:0] dv, ed;
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, (c % 2 == 0) ? HTRANS_IDLE : HTRANS_BUSY);
            @(negedge clk);
            n_checks++;
            if (t_hready[0] !== 1'b1 || t_hresp[0] !== 1'b0)
                $display("FAIL idle_cycle%0d: got hready=%b hresp=%b expected hready=1 hresp=0", c, t_hready[0], t_hresp[0]);
            else n_pass++;
        end
        model_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== 32'hDEADBEAA) $display("FAIL idle_no_write: got %h expected deadbeaa", dv);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            int s, kind, w, ew;
            logic wr, f, l, er;
            logic [31:0] a, d, dv, ed;
            logic [3:0] m;
            logic [1:0] ht;
            s    = $urandom_range(1);
            kind = $urandom_range(9);
            wr   = 1'($urandom_range(1));
            d    = $urandom;
            m    = 4'($urandom_range(15));
            ht   = ($urandom_range(1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
            a    = rand_addr_in(s) | 32'($urandom_range(3));
            if (kind == 0) ht = ($urandom_range(1) != 0) ? HTRANS_IDLE : HTRANS_BUSY;
            else if (kind == 1) a = rand_addr_out(s);
            model_xfer(s, wr, a, d, m, ht, ew, er, ed);
            run_xfer(s, wr, a, d, m, ht, w, f, l, dv);
            n_checks++;
            if (w !== ew || f !== er || l !== er || dv !== ed)
                $display("FAIL rand%0d dut%0d addr=%h wr=%b ht=%b: got waits=%0d hresp=%b/%b data=%h expected waits=%0d hresp=%b/%b data=%h",
                         k, s, a, wr, ht, w, f, l, dv, ew, er, er, ed);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_err();
        int w, ew; logic f, l, er; logic [31:0] dv, ed, d;
        model_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== ed) $display("FAIL pre_reset_read: got %h expected %h", dv, ed);
        else n_pass++;
        d = $urandom;
        model_xfer(0, 1'b1, 32'h800, 32'h0, 4'hF, HTRANS_NONSEQ, ew, er, ed);
        model_xfer(1, 1'b1, BASE1 + 32'h40, d, 4'hF, HTRANS_NONSEQ, ew, er, ed);
        drive(0, 1'b1, 32'h800, 32'h0, 4'hF, HTRANS_NONSEQ);
        drive(1, 1'b1, BASE1 + 32'h40, d, 4'hF, HTRANS_NONSEQ);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, HTRANS_IDLE);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, HTRANS_IDLE);
        n_checks++;
        if (t_hready[0] !== 1'b0 || t_hresp[0] !== 1'b1 || t_hready[1] !== 1'b0)
            $display("FAIL enter_err1_wait: got hready0=%b hresp0=%b hready1=%b expected 0 1 0", t_hready[0], t_hresp[0], t_hready[1]);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        exp_dout[0] = 32'h0;
        exp_dout[1] = 32'h0;
        n_checks++;
        if (t_hready[0] !== 1'b1 || t_hresp[0] !== 1'b0 || t_dout[0] !== 32'h0)
            $display("FAIL async_reset_err: got hready=%b hresp=%b data=%h expected 1 0 00000000", t_hready[0], t_hresp[0], t_dout[0]);
        else n_pass++;
        n_checks++;
        if (t_hready[1] !== 1'b1 || t_dout[1] !== 32'h0)
            $display("FAIL async_reset_wait: got hready=%b data=%h expected 1 00000000", t_hready[1], t_dout[1]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_xfer(1, 1'b0, BASE1 + 32'h40, 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
        run_xfer(1, 1'b0, BASE1 + 32'h40, 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
        n_checks++;
        if (dv !== d || w !== 3) $display("FAIL write_survives_reset: got %h waits=%0d expected %h waits=3", dv, w, d);
        else n_pass++;
    endtask

    task automatic test_readback_all();
        int w, ew; logic f, l, er; logic [31:0] dv, ed;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < depth_of[s]; i++) begin
                model_xfer(s, 1'b0, base_of[s] + 32'(4 * i), 32'h0, 4'h0, HTRANS_NONSEQ, ew, er, ed);
                run_xfer(s, 1'b0, base_of[s] + 32'(4 * i), 32'h0, 4'h0, HTRANS_NONSEQ, w, f, l, dv);
                n_checks++;
                if (dv !== ed || w !== ew || l !== 1'b0)
                    $display("FAIL scan dut%0d word%0d: got %h waits=%0d hresp=%b expected %h waits=%0d hresp=0", s, i, dv, w, l, ed, ew);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        fill_memories();
        test_write_read();
        test_partial_write();
        test_wait_states();
        test_out_of_range();
        test_idle_no_write();
        test_back_to_back();
        test_reset_in_err();
        test_readback_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion within time limit, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
